// File: rtl/simd_writeback_unit_pkg.sv
// Shared types for the SIMD writeback path: FSM state encoding and default widths.
package simd_pkg;

  localparam int SIMD_DATA_WIDTH = 32;
  localparam int SIMD_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_RUN  = 2'd1,
    WB_DONE = 2'd2
  } wb_state_e;

endpackage

// File: rtl/simd_writeback_unit_if.sv
// Bundle of job configuration, lane-result handshake and scratchpad write port.
interface simd_wb_if
  import simd_pkg::*;
#(
  parameter int DATA_WIDTH  = SIMD_DATA_WIDTH,
  parameter int ADDR_WIDTH  = SIMD_ADDR_WIDTH,
  parameter int COUNT_WIDTH = 16
);

  logic                   cfg_start;
  logic [ADDR_WIDTH-1:0]  cfg_base;
  logic [ADDR_WIDTH-1:0]  cfg_stride;
  logic [COUNT_WIDTH-1:0] cfg_count;

  logic                   res_valid;
  logic [DATA_WIDTH-1:0]  res_data;
  logic                   res_ready;

  logic                   wr_valid;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   wr_ready;

  logic                   busy;
  logic                   done;

  modport slave (
    input  cfg_start, cfg_base, cfg_stride, cfg_count,
    input  res_valid, res_data, wr_ready,
    output res_ready, wr_valid, wr_addr, wr_data, busy, done
  );

  modport master (
    output cfg_start, cfg_base, cfg_stride, cfg_count,
    output res_valid, res_data, wr_ready,
    input  res_ready, wr_valid, wr_addr, wr_data, busy, done
  );

endinterface

// File: rtl/simd_wb_fifo.sv
// Synchronous show-ahead FIFO: dout always presents the oldest entry; flush empties it.
module simd_wb_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty;
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only, so it is left out of the reset domain.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/simd_writeback_unit.sv
// Buffers lane results and drains them to the scratchpad at base + k*stride.
// Optional SIMD_WB_STALL_CNT_EN adds a saturating stall_cycles backpressure counter.
module simd_writeback_unit
  import simd_pkg::*;
#(
  parameter int DATA_WIDTH  = SIMD_DATA_WIDTH,
  parameter int ADDR_WIDTH  = SIMD_ADDR_WIDTH,
  parameter int FIFO_DEPTH  = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  simd_wb_if.slave    wb
`ifdef SIMD_WB_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  wb_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]  stride_q, stride_d;
  logic [COUNT_WIDTH-1:0] total_q, total_d;
  logic [COUNT_WIDTH-1:0] elem_q, elem_d;
  logic                   res_ready_q, res_ready_d;

  logic                   fifo_push, fifo_pop, fifo_flush;
  logic                   fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0]  fifo_dout;
  logic [CNT_W-1:0]       fifo_count, occ_next;
  logic                   wr_valid_w, last_pop;

  assign wr_valid_w = (state_q == WB_RUN) & ~fifo_empty;
  assign fifo_pop   = wr_valid_w & wb.wr_ready;
  assign fifo_push  = wb.res_valid & res_ready_q & ~fifo_full;
  assign last_pop   = fifo_pop & (elem_q == total_q - COUNT_WIDTH'(1));

  simd_wb_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wb.res_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    stride_d   = stride_q;
    total_d    = total_q;
    elem_d     = elem_q;
    fifo_flush = 1'b0;
    case (state_q)
      WB_IDLE: begin
        if (wb.cfg_start) begin
          addr_d   = wb.cfg_base;
          stride_d = wb.cfg_stride;
          total_d  = wb.cfg_count;
          elem_d   = '0;
          state_d  = (wb.cfg_count == '0) ? WB_DONE : WB_RUN;
        end
      end
      WB_RUN: begin
        if (fifo_pop) begin
          addr_d = addr_q + stride_q;
          elem_d = elem_q + COUNT_WIDTH'(1);
          if (last_pop) state_d = WB_DONE;
        end
      end
      WB_DONE: begin
        fifo_flush = 1'b1;
        state_d    = WB_IDLE;
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // res_ready looks at the occupancy this edge will leave behind, so a full
  // FIFO keeps it low for the whole cycle even when it is being popped.
  always_comb begin
    occ_next = fifo_count;
    case ({fifo_push, fifo_pop})
      2'b10:   occ_next = fifo_count + CNT_W'(1);
      2'b01:   occ_next = fifo_count - CNT_W'(1);
      default: occ_next = fifo_count;
    endcase
    res_ready_d = (state_d == WB_RUN) && (occ_next < CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WB_IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      total_q     <= '0;
      elem_q      <= '0;
      res_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      total_q     <= total_d;
      elem_q      <= elem_d;
      res_ready_q <= res_ready_d;
    end
  end

  assign wb.res_ready = res_ready_q;
  assign wb.wr_valid  = wr_valid_w;
  assign wb.wr_addr   = addr_q;
  assign wb.wr_data   = wr_valid_w ? fifo_dout : '0;
  assign wb.busy      = (state_q == WB_RUN);
  assign wb.done      = (state_q == WB_DONE);

`ifdef SIMD_WB_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    stall_d = stall_q;
    if ((state_q == WB_IDLE) && wb.cfg_start) begin
      stall_d = '0;
    end else if (wr_valid_w && !wb.wr_ready) begin
      stall_d = sat_inc32(stall_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

`ifndef SYNTHESIS
  a_res_no_drop: assert property (@(posedge clk) disable iff (reset)
    wb.res_valid |-> res_ready_q)
    else $error("res_valid asserted while res_ready low; result dropped");
`endif

endmodule
